dmem_req_ctrl: RTL and testbench
================================

// Module: dmem_req_ctrl
// PURPOSE
//  Data-memory request controller between mem_stage and the data cache port.
//  Registers each load/store request from mem_stage and holds it stable until
//  the cache responds, stalling the pipeline meanwhile.
//  Captures read data for the MEM/WB boundary, squashes flushed requests and
//  bounds every access with a timeout.
// PARAMETERS
//  WIDTH           16   data/address width (lc3b_word)
//  TIMEOUT_CYCLES  255  max cycles in BUSY before abort; must be >= 1
// PORTS
//  clk             in   1      clock; all state on rising edge
//  rst_n           in   1      reset, asynchronous assert, active low
//  mem_read_in     in   1      load request from mem_stage (mem_read)
//  mem_write_in    in   1      store request from mem_stage (mem_write)
//  addr_in         in   WIDTH  mem_address from mem_stage
//  wdata_in        in   WIDTH  mem_wdata from mem_stage (already byte-shifted)
//  byte_en_in      in   2      mem_byte_enable from mem_stage
//  flush           in   1      squash the current MEM-stage instruction
//  dc_resp         in   1      cache response; one-cycle pulse
//  dc_rdata        in   WIDTH  cache read data; valid when dc_resp=1
//  dc_read         out  1      registered cache read strobe
//  dc_write        out  1      registered cache write strobe
//  dc_address      out  WIDTH  held request address
//  dc_wdata        out  WIDTH  held write data
//  dc_byte_enable  out  2      held byte enables
//  stall           out  1      pipeline hold request; combinational
//  rdata_out       out  WIDTH  captured load data, fed to mem_stage mem_rdata
//  rdata_valid     out  1      one-cycle pulse: rdata_out holds new load data
//  timeout_err     out  1      one-cycle pulse: access aborted by timeout
//  illegal_req     out  1      one-cycle pulse: read and write both asserted
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE; all dc_* outputs, rdata_out and pulses = 0; counter = 0;
//     kill flag = 0.
//   - Reset mid-transaction drops the request. A late dc_resp arriving in IDLE
//     is ignored.
//  req = mem_read_in ^ mem_write_in. Both asserted: illegal_req pulses, no
//   access is issued, stall=0.
//  States:
//   IDLE: req & ~flush -> latch addr/wdata/be and read/write into hold regs,
//     go BUSY. stall=1 in this cycle (combinational on req).
//     req & flush -> no access, stay IDLE, stall=0.
//   BUSY: dc_read/dc_write driven from hold regs; stall=1; counter increments.
//     dc_resp -> capture dc_rdata into rdata_out on loads; go DONE.
//     counter == TIMEOUT_CYCLES-1 with no resp -> go ERR.
//     flush in BUSY -> set kill; request stays on bus until resp (cache
//     transaction is never abandoned).
//   DONE (1 cycle): dc_read/dc_write=0; stall=0 so the pipeline advances;
//     rdata_valid=1 if load & ~kill. Clear kill; go IDLE unconditionally (the
//     packet seen in DONE is the one just serviced).
//   ERR (1 cycle): strobes=0; stall=0; timeout_err=1; rdata_out=16'h0000;
//     kill cleared; go IDLE.
//  Latency: strobes first high 1 cycle after request is seen; minimum load
//   latency is IDLE->BUSY->DONE = 3 cycles with resp in first BUSY cycle.
//  Hold regs are not modified outside IDLE: addr_in changes during BUSY have
//   no effect on dc_*.
//  Counter width $clog2(TIMEOUT_CYCLES+1). Reset to 0 on entering BUSY. No
//   wrap: ERR is taken first.
//  dc_resp together with the timeout terminal count: resp wins (DONE).
//  Stores: rdata_out keeps its previous value; rdata_valid=0.
// STRUCTURE
//  lc3b_types: add enum dmem_state_t {IDLE,BUSY,DONE,ERR}; use lc3b_word for
//   WIDTH=16 ports.
//  One sub-module: dmem_timeout_ctr (clear, enable, terminal-count output).
// TESTING
//  Load 0x1234, resp after 2 BUSY cycles with rdata 0xBEEF -> dc_read high for
//   exactly 3 cycles, stall high 4 cycles, rdata_out=0xBEEF, rdata_valid 1 pulse.
//  Store addr 0x0042, wdata 0x00AB, be 2'b01, resp immediate -> dc_write 1
//   cycle with held values; rdata_valid=0; rdata_out unchanged.
//  TIMEOUT_CYCLES=4, load with no resp -> 4 BUSY cycles, then ERR:
//   timeout_err pulse, rdata_out=0, stall drops.
//  Load, flush in 2nd BUSY cycle, resp 0x5555 in 3rd -> no rdata_valid; back to
//   IDLE after DONE.
//  rst_n low mid-BUSY, then dc_resp pulse in IDLE -> all outputs 0 at once;
//   resp ignored.
//  mem_read_in=mem_write_in=1 -> illegal_req pulse, no dc strobe, stall=0.

Source files
------------

// File: rtl/dmem_req_ctrl_pkg.sv
// Shared types for the data-memory request controller.
package dmem_req_ctrl_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Access timeout counter: cleared when a request is accepted, counts while busy,
// saturates at the terminal count so it never wraps.
module dmem_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != TermCnt)) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_terminal = (r_cnt == TermCnt);

endmodule

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: holds one load/store on the cache port until the
// cache responds or the access times out, stalling the pipeline meanwhile.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] wdata_in,
    input  logic [1:0]       byte_en_in,
    input  logic             flush,
    input  logic             dc_resp,
    input  logic [WIDTH-1:0] dc_rdata,
    output logic             dc_read,
    output logic             dc_write,
    output logic [WIDTH-1:0] dc_address,
    output logic [WIDTH-1:0] dc_wdata,
    output logic [1:0]       dc_byte_enable,
    output logic             stall,
    output logic [WIDTH-1:0] rdata_out,
    output logic             rdata_valid,
    output logic             timeout_err,
    output logic             illegal_req
);

    dmem_state_t      r_state;
    logic             r_dc_read;
    logic             r_dc_write;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [1:0]       r_be;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rdata_valid;
    logic             r_timeout_err;
    logic             r_illegal;
    logic             r_kill;

    logic w_req;
    logic w_start;
    logic w_busy;
    logic w_terminal;

    // Read and write together is illegal, so XOR rejects it as a request.
    assign w_req   = mem_read_in ^ mem_write_in;
    assign w_start = (r_state == StIdle) && w_req && !flush;
    assign w_busy  = (r_state == StBusy);

    dmem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start),
        .i_enable   (w_busy),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_dc_read     <= 1'b0;
            r_dc_write    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_illegal     <= 1'b0;
            r_kill        <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_illegal     <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_illegal <= mem_read_in & mem_write_in;
                    if (w_start) begin
                        r_dc_read  <= mem_read_in;
                        r_dc_write <= mem_write_in;
                        r_addr     <= addr_in;
                        r_wdata    <= wdata_in;
                        r_be       <= byte_en_in;
                        r_kill     <= 1'b0;
                        r_state    <= StBusy;
                    end
                end
                StBusy: begin
                    // A flushed access still completes on the bus; only its result is dropped.
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (dc_resp) begin
                        if (r_dc_read) begin
                            r_rdata <= dc_rdata;
                        end
                        r_rdata_valid <= r_dc_read & ~r_kill & ~flush;
                        r_dc_read     <= 1'b0;
                        r_dc_write    <= 1'b0;
                        r_state       <= StDone;
                    end else if (w_terminal) begin
                        r_rdata       <= '0;
                        r_timeout_err <= 1'b1;
                        r_dc_read     <= 1'b0;
                        r_dc_write    <= 1'b0;
                        r_state       <= StErr;
                    end
                end
                StDone, StErr: begin
                    r_kill  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign dc_read        = r_dc_read;
    assign dc_write       = r_dc_write;
    assign dc_address     = r_addr;
    assign dc_wdata       = r_wdata;
    assign dc_byte_enable = r_be;
    assign stall          = w_start | w_busy;
    assign rdata_out      = r_rdata;
    assign rdata_valid    = r_rdata_valid;
    assign timeout_err    = r_timeout_err;
    assign illegal_req    = r_illegal;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Scoreboard bench for dmem_req_ctrl: stimulus queues expected accesses and result
// pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_req_ctrl;

    localparam int unsigned Tmo = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] wdata_in = '0;
    logic [1:0]  byte_en_in = '0;
    logic        flush = 1'b0;
    logic        dc_resp = 1'b0;
    logic [15:0] dc_rdata = '0;
    logic        dc_read;
    logic        dc_write;
    logic [15:0] dc_address;
    logic [15:0] dc_wdata;
    logic [1:0]  dc_byte_enable;
    logic        stall;
    logic [15:0] rdata_out;
    logic        rdata_valid;
    logic        timeout_err;
    logic        illegal_req;

    always #5 clk = ~clk;

    dmem_req_ctrl #(
        .WIDTH          (16),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .byte_en_in     (byte_en_in),
        .flush          (flush),
        .dc_resp        (dc_resp),
        .dc_rdata       (dc_rdata),
        .dc_read        (dc_read),
        .dc_write       (dc_write),
        .dc_address     (dc_address),
        .dc_wdata       (dc_wdata),
        .dc_byte_enable (dc_byte_enable),
        .stall          (stall),
        .rdata_out      (rdata_out),
        .rdata_valid    (rdata_valid),
        .timeout_err    (timeout_err),
        .illegal_req    (illegal_req)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          ncyc;
        logic [15:0] end_rdata;
    } acc_t;

    // kind bits: {illegal_req, timeout_err, rdata_valid}
    typedef struct {
        logic [2:0]  kind;
        logic [15:0] rdata;
    } res_t;

    acc_t acc_q[$];
    res_t res_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_active = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic acc_t mk_acc(input logic rd, input logic wr, input logic [15:0] a,
                                    input logic [15:0] wd, input logic [1:0] be,
                                    input int ncyc, input logic [15:0] end_rd);
        acc_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd; t.be = be;
        t.ncyc = ncyc; t.end_rdata = end_rd;
        return t;
    endfunction

    function automatic res_t mk_res(input logic [2:0] kind, input logic [15:0] rd);
        res_t r;
        r.kind = kind; r.rdata = rd;
        return r;
    endfunction

    // Monitor
    initial begin : monitor
        acc_t cur;
        res_t r;
        logic prev_strobe;
        logic strobe;
        logic [2:0] kind;
        int len;
        prev_strobe = 1'b0;
        len = 0;
        forever begin
            @(negedge clk);
            strobe = dc_read | dc_write;
            if (strobe && !prev_strobe) begin
                chk("access_expected", 32'(acc_q.size() != 0), 1);
                if (acc_q.size() != 0) begin
                    cur = acc_q.pop_front();
                    mon_active = 1;
                    len = 0;
                end
            end
            if (strobe && mon_active) begin
                len++;
                chk("dc_read", dc_read, cur.rd);
                chk("dc_write", dc_write, cur.wr);
                chk("dc_address", dc_address, cur.addr);
                chk("dc_wdata", dc_wdata, cur.wdata);
                chk("dc_byte_enable", dc_byte_enable, cur.be);
            end
            if (!strobe && prev_strobe && mon_active) begin
                chk("strobe_len", len, cur.ncyc);
                chk("end_rdata_out", rdata_out, cur.end_rdata);
                mon_active = 0;
            end
            prev_strobe = strobe;
            kind = {illegal_req, timeout_err, rdata_valid};
            if (kind != 3'b000) begin
                chk("pulse_expected", 32'(res_q.size() != 0), 1);
                if (res_q.size() != 0) begin
                    r = res_q.pop_front();
                    chk("pulse_kind", kind, r.kind);
                    chk("pulse_rdata_out", rdata_out, r.rdata);
                end
            end
        end
    end

    // Drives one request; cycle 0 is the IDLE request cycle, cycle k>=1 is the k-th
    // BUSY cycle. Inputs are scrambled from cycle 1 to prove the hold registers.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd,
                              input logic [1:0] be, input int resp_at,
                              input logic [15:0] rdat, input int flush_at,
                              input int exp_stall);
        int n;
        bit done;
        n = 0;
        done = 0;
        mem_read_in = rd; mem_write_in = wr;
        addr_in = a; wdata_in = wd; byte_en_in = be;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 1) begin
                addr_in = ~a; wdata_in = ~wd; byte_en_in = ~be;
            end
            dc_resp  = (c == resp_at);
            dc_rdata = (c == resp_at) ? rdat : 16'hDEAD;
            flush    = (c == flush_at);
            @(negedge clk);
            if (stall) n++;
            else done = 1;
            @(posedge clk);
            #1;
        end
        chk({name, "_finished"}, 32'(done), 1);
        chk({name, "_stall_cycles"}, n, exp_stall);
        mem_read_in = 0; mem_write_in = 0; flush = 0; dc_resp = 0;
        addr_in = '0; wdata_in = '0; byte_en_in = '0;
    endtask

    initial begin : stim
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dc_read", dc_read, 0);
        chk("rst_dc_write", dc_write, 0);
        chk("rst_dc_address", dc_address, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata_out", rdata_out, 0);
        chk("rst_pulses", {rdata_valid, timeout_err, illegal_req}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        // Load 0x1234, response in 3rd BUSY cycle
        acc_q.push_back(mk_acc(1, 0, 16'h1234, 16'h0000, 2'b11, 3, 16'hBEEF));
        res_q.push_back(mk_res(3'b001, 16'hBEEF));
        run_access("load", 1, 0, 16'h1234, 16'h0000, 2'b11, 3, 16'hBEEF, -1, 4);

        // Store, immediate response, rdata_out keeps 0xBEEF
        acc_q.push_back(mk_acc(0, 1, 16'h0042, 16'h00AB, 2'b01, 1, 16'hBEEF));
        run_access("store", 0, 1, 16'h0042, 16'h00AB, 2'b01, 1, 16'h9999, -1, 2);

        // Timeout: no response for Tmo BUSY cycles
        acc_q.push_back(mk_acc(1, 0, 16'h0100, 16'h0000, 2'b11, 4, 16'h0000));
        res_q.push_back(mk_res(3'b010, 16'h0000));
        run_access("timeout", 1, 0, 16'h0100, 16'h0000, 2'b11, -1, 16'h0, -1, 5);

        // Minimum latency load
        acc_q.push_back(mk_acc(1, 0, 16'h0200, 16'h0000, 2'b10, 1, 16'h1111));
        res_q.push_back(mk_res(3'b001, 16'h1111));
        run_access("minload", 1, 0, 16'h0200, 16'h0000, 2'b10, 1, 16'h1111, -1, 2);

        // Flush in 2nd BUSY cycle, response in 3rd: data captured, no valid pulse
        acc_q.push_back(mk_acc(1, 0, 16'h0300, 16'h0000, 2'b11, 3, 16'h5555));
        run_access("flushbusy", 1, 0, 16'h0300, 16'h0000, 2'b11, 3, 16'h5555, 2, 4);

        // Request with flush in IDLE: nothing issued
        run_access("flushidle", 1, 0, 16'h0400, 16'h0000, 2'b11, -1, 16'h0, 0, 0);

        // Read and write together
        res_q.push_back(mk_res(3'b100, 16'h5555));
        mem_read_in = 1; mem_write_in = 1; addr_in = 16'h0500;
        @(negedge clk);
        chk("illegal_stall", stall, 0);
        @(posedge clk);
        #1 mem_read_in = 0; mem_write_in = 0; addr_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of BUSY, then a stray response in IDLE
        acc_q.push_back(mk_acc(1, 0, 16'h0600, 16'h0000, 2'b11, 2, 16'h0000));
        mem_read_in = 1; addr_in = 16'h0600; byte_en_in = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst_n = 0; mem_read_in = 0; addr_in = '0; byte_en_in = '0;
        #1;
        chk("midrst_dc_read", dc_read, 0);
        chk("midrst_dc_address", dc_address, 0);
        chk("midrst_dc_byte_enable", dc_byte_enable, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_rdata_out", rdata_out, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1 dc_resp = 1; dc_rdata = 16'h7777;
        @(posedge clk);
        #1 dc_resp = 0; dc_rdata = '0;
        @(negedge clk);
        chk("late_resp_rdata_out", rdata_out, 0);
        chk("late_resp_dc_read", dc_read, 0);
        chk("late_resp_stall", stall, 0);

        repeat (4) @(posedge clk);
        chk("acc_q_drained", acc_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        chk("monitor_idle", 32'(mon_active), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
